// File: rtl/forward_data_supplier_pkg.sv
// rtl/forward_data_supplier_pkg.sv - forwarding select encodings and history slot record
// Shared with the forwarding unit so both sides agree on select meaning.
package forward_data_supplier_pkg;

  localparam int FWD_SLOTS    = 3;
  // Slot record is sized for the pipeline datapath; DATA_WIDTH/REG_BITS must not exceed these.
  localparam int FWD_DATA_MAX = 32;
  localparam int FWD_REG_MAX  = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_PC4  = 2'd1,
    FWD_PC8  = 2'd2,
    FWD_PC12 = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic                    valid;
    logic                    pending;
    logic [FWD_REG_MAX-1:0]  rd;
    logic [FWD_DATA_MAX-1:0] data;
  } fwd_slot_t;

endpackage

// File: rtl/forward_data_supplier_if.sv
// rtl/forward_data_supplier_if.sv - pipeline-side bus of the forward data supplier
// master = pipeline/forwarding unit, slave = supplier.
interface forward_data_supplier_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_BITS   = 5
);
  logic [DATA_WIDTH-1:0] EXE_Result;
  logic [REG_BITS-1:0]   EXE_WriteReg;
  logic                  EXE_RegWrite;
  logic                  EXE_Load;
  logic                  MEM_LoadValid;
  logic [DATA_WIDTH-1:0] MEM_LoadData;
  logic                  hold;
  logic [1:0]            EXE_A_Select;
  logic [1:0]            EXE_B_Select;
  logic [1:0]            MEM_Data_select;
  logic [1:0]            Branch_JR_select_A;
  logic [1:0]            Branch_JR_select_B;
  logic [DATA_WIDTH-1:0] Alt_RegA;
  logic [DATA_WIDTH-1:0] Alt_RegB;
  logic [DATA_WIDTH-1:0] Alt_MEM_Data;
  logic [DATA_WIDTH-1:0] Alt_BrA;
  logic [DATA_WIDTH-1:0] Alt_BrB;
  logic                  data_pending;
  logic                  fill_error;

  modport master (
    output EXE_Result, EXE_WriteReg, EXE_RegWrite, EXE_Load,
    output MEM_LoadValid, MEM_LoadData, hold,
    output EXE_A_Select, EXE_B_Select, MEM_Data_select,
    output Branch_JR_select_A, Branch_JR_select_B,
    input  Alt_RegA, Alt_RegB, Alt_MEM_Data, Alt_BrA, Alt_BrB,
    input  data_pending, fill_error
  );

  modport slave (
    input  EXE_Result, EXE_WriteReg, EXE_RegWrite, EXE_Load,
    input  MEM_LoadValid, MEM_LoadData, hold,
    input  EXE_A_Select, EXE_B_Select, MEM_Data_select,
    input  Branch_JR_select_A, Branch_JR_select_B,
    output Alt_RegA, Alt_RegB, Alt_MEM_Data, Alt_BrA, Alt_BrB,
    output data_pending, fill_error
  );
endinterface

// File: rtl/forward_data_supplier_fwd_select_mux.sv
// rtl/forward_data_supplier_fwd_select_mux.sv - one forwarding select over the history slots
// Returns slot data (or in-flight fill data) and a load-use pending flag.
module fwd_select_mux
  import forward_data_supplier_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_BITS   = 5
) (
  input  logic [1:0]                 sel,
  input  fwd_slot_t [FWD_SLOTS-1:0]  slots,
  input  logic [FWD_SLOTS-1:0]       fill_hit,
  input  logic [DATA_WIDTH-1:0]      fill_data,
  output logic [DATA_WIDTH-1:0]      data,
  output logic                       pending
);

  fwd_slot_t slot;
  logic      hit;

  always_comb begin
    slot = '0;
    hit  = 1'b0;
    case (fwd_sel_e'(sel))
      FWD_PC4:  begin slot = slots[0]; hit = fill_hit[0]; end
      FWD_PC8:  begin slot = slots[1]; hit = fill_hit[1]; end
      FWD_PC12: begin slot = slots[2]; hit = fill_hit[2]; end
      default:  begin slot = '0;       hit = 1'b0;        end
    endcase
  end

  always_comb begin
    data    = '0;
    pending = 1'b0;
    // r0 is rejected again here so a corrupted slot can never forward it.
    if (slot.valid && (slot.rd[REG_BITS-1:0] != '0)) begin
      if (hit) begin
        data = fill_data;
      end else if (slot.pending) begin
        pending = 1'b1;
      end else begin
        data = slot.data[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/forward_data_supplier.sv
// rtl/forward_data_supplier.sv - three-deep result history with load fill and five forwarding ports
// S1/S2/S3 hold the results of the instructions at PC-4/PC-8/PC-12.
module forward_data_supplier
  import forward_data_supplier_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_BITS   = 5
) (
  input  logic                   CLK,
  input  logic                   RESET,
  forward_data_supplier_if.slave bus
);

  localparam int NUM_PORTS = 5;

  fwd_slot_t [FWD_SLOTS-1:0] slot_q;
  fwd_slot_t [FWD_SLOTS-1:0] slot_d;
  fwd_slot_t [FWD_SLOTS-1:0] filled;
  fwd_slot_t                 new_s1;
  logic [FWD_SLOTS-1:0]      fill_hit;
  logic                      fill_error_q;
  logic                      fill_error_d;

  logic [NUM_PORTS-1:0][1:0]            sel_v;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data_v;
  logic [NUM_PORTS-1:0]                 pend_v;

  // Returned load data always belongs to the oldest outstanding load.
  always_comb begin
    fill_hit = '0;
    if (bus.MEM_LoadValid) begin
      if (slot_q[2].valid && slot_q[2].pending) begin
        fill_hit = 3'b100;
      end else if (slot_q[1].valid && slot_q[1].pending) begin
        fill_hit = 3'b010;
      end else if (slot_q[0].valid && slot_q[0].pending) begin
        fill_hit = 3'b001;
      end
    end
  end

  always_comb begin
    new_s1         = '0;
    new_s1.valid   = bus.EXE_RegWrite && (bus.EXE_WriteReg != '0);
    new_s1.pending = new_s1.valid && bus.EXE_Load;
    new_s1.rd[REG_BITS-1:0] = bus.EXE_WriteReg;
    if (!new_s1.pending) begin
      new_s1.data[DATA_WIDTH-1:0] = bus.EXE_Result;
    end

    filled = slot_q;
    for (int i = 0; i < FWD_SLOTS; i++) begin
      if (fill_hit[i]) begin
        filled[i].pending = 1'b0;
        filled[i].data    = '0;
        filled[i].data[DATA_WIDTH-1:0] = bus.MEM_LoadData;
      end
    end

    slot_d       = filled;
    fill_error_d = fill_error_q;
    if (bus.MEM_LoadValid && (fill_hit == '0)) begin
      fill_error_d = 1'b1;
    end
    if (!bus.hold) begin
      // Filling first then shifting puts the fill at its post-shift slot; S3 falls off the end.
      slot_d = {filled[1], filled[0], new_s1};
      if (fill_hit[2]) begin
        fill_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      slot_q       <= '0;
      fill_error_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      fill_error_q <= fill_error_d;
    end
  end

  assign sel_v = {bus.Branch_JR_select_B, bus.Branch_JR_select_A,
                  bus.MEM_Data_select, bus.EXE_B_Select, bus.EXE_A_Select};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_mux
    fwd_select_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_BITS   (REG_BITS)
    ) u_mux (
      .sel       (sel_v[g]),
      .slots     (slot_q),
      .fill_hit  (fill_hit),
      .fill_data (bus.MEM_LoadData),
      .data      (data_v[g]),
      .pending   (pend_v[g])
    );
  end

  assign bus.Alt_RegA     = RESET ? '0 : data_v[0];
  assign bus.Alt_RegB     = RESET ? '0 : data_v[1];
  assign bus.Alt_MEM_Data = RESET ? '0 : data_v[2];
  assign bus.Alt_BrA      = RESET ? '0 : data_v[3];
  assign bus.Alt_BrB      = RESET ? '0 : data_v[4];
  assign bus.data_pending = !RESET && (|pend_v);
  assign bus.fill_error   = !RESET && fill_error_q;

endmodule

// File: doc/forward_data_supplier.md
FORWARD_DATA_SUPPLIER -- requirements
Module: forward_data_supplier

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of forwarded data.
REQ-002 SHALL have parameter REG_BITS, default 5, width of register specifiers.
REQ-003 SHALL have port CLK  input  1  pipeline clock, all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port EXE_Result  input  DATA_WIDTH  ALU result of the instruction leaving EXE.
REQ-006 SHALL have port EXE_WriteReg  input  REG_BITS  destination register of that instruction.
REQ-007 SHALL have port EXE_RegWrite  input  1  that instruction writes a register.
REQ-008 SHALL have port EXE_Load  input  1  that instruction is a load; its data arrives later.
REQ-009 SHALL have port MEM_LoadValid  input  1  load data returned this cycle.
REQ-010 SHALL have port MEM_LoadData  input  DATA_WIDTH  returned load data.
REQ-011 SHALL have port hold  input  1  pipeline frozen; history does not shift.
REQ-012 SHALL have ports EXE_A_Select, EXE_B_Select, MEM_Data_select, Branch_JR_select_A, Branch_JR_select_B  input  2 each  forwarding selects (0 none, 1 PC-4, 2 PC-8, 3 PC-12).
REQ-013 SHALL have ports Alt_RegA, Alt_RegB, Alt_MEM_Data, Alt_BrA, Alt_BrB  output  DATA_WIDTH each  forwarded data per select.
REQ-014 SHALL have port data_pending  output  1  a nonzero select targets a slot whose load data has not arrived (load-use stall request).
REQ-015 SHALL have port fill_error  output  1  sticky: MEM_LoadValid with no pending slot.

Function
REQ-016 SHALL hold three history slots S1 (PC-4), S2 (PC-8), S3 (PC-12), each {valid, pending, reg, data}.
REQ-017 SHALL, on a rising edge with hold=0, shift S3<=S2, S2<=S1, and load S1 from EXE inputs.
REQ-018 SHALL load S1 with valid=EXE_RegWrite & (EXE_WriteReg!=0), pending=valid & EXE_Load, data=EXE_Result (0 if pending).
REQ-019 SHALL, with hold=1, leave slot contents unshifted; EXE inputs ignored.
REQ-020 SHALL, on MEM_LoadValid, write MEM_LoadData into the oldest pending slot and clear its pending bit.
REQ-021 SHALL, when fill and shift occur in the same edge, apply the fill to the slot at its post-shift position; a fill to S3 coincident with shift is discarded and sets fill_error.
REQ-022 SHALL set fill_error when MEM_LoadValid=1 and no slot is pending; it stays set until RESET.
REQ-023 SHALL drive each Alt output combinationally from the selected slot data (zero added latency); select 0 or invalid slot yields 0.
REQ-024 SHALL assert data_pending combinationally when any nonzero select targets a valid slot with pending=1.
REQ-025 SHALL give a fill bypass: a select targeting the slot being filled this cycle returns MEM_LoadData and does not raise data_pending.
REQ-026 SHALL never make register 0 forwardable.

Reset
REQ-027 SHALL, on RESET assertion regardless of CLK, clear all valid, pending, reg, data bits and fill_error.
REQ-028 SHALL drive all Alt outputs, data_pending and fill_error to 0 while RESET is high.
REQ-029 SHALL discard any load data in flight when reset occurs mid-operation; first MEM_LoadValid after reset with no pending slot sets fill_error.

Structure
REQ-030 SHALL take select encodings (NONE=0, PC4=1, PC8=2, PC12=3) and the slot record type from the shared pipeline package, shared with the forwarding unit.
REQ-031 SHALL instantiate one sub-module fwd_select_mux five times, mapping select plus slot array to data and pending flag.

Verification
REQ-032 SHALL cover: ALU write r5=0x1234 then A_Select=1 next cycle -> Alt_RegA=0x1234, data_pending=0.
REQ-033 SHALL cover: load r8 then B_Select=1 before fill -> data_pending=1; MEM_LoadValid data 0xDEADBEEF same cycle -> Alt_RegB=0xDEADBEEF, data_pending=0.
REQ-034 SHALL cover: writes r1,r2,r3 on three edges -> selects 3/2/1 return r1/r2/r3 data; fourth edge drops r1.
REQ-035 SHALL cover: hold=1 for two cycles with new EXE inputs -> slot contents and Alt outputs unchanged.
REQ-036 SHALL cover: write to r0 with EXE_RegWrite=1 -> select 1 returns 0; MEM_LoadValid with nothing pending -> fill_error=1 until RESET.
REQ-037 SHALL cover: RESET asserted between edges with pending load -> outputs 0 immediately, subsequent fill sets fill_error.
